// File: rtl/bridge_arb_pkg.sv
// Shared types and defaults for the bridge round-robin arbiter.
package bridge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_NUM_REQ  = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/bridge_arbiter_rr_pick.sv
// Combinational round-robin picker: rotates req by rr_ptr over a doubled
// vector and priority-encodes the first set bit at or after the pointer.
module rr_pick
  import bridge_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     winner,
  output logic               any
);

  localparam int DW = 2*NUM_REQ-1;
  localparam int PW = $clog2(DW);

  logic [DW-1:0]      dbl_s;
  logic [NUM_REQ-1:0] rot_s;
  logic [PW-1:0]      idx_s;
  logic [IDW-1:0]     off_s;
  logic               found_s;
  logic [IDW:0]       sum_s;

  // The top copy drops its MSB: no rotation ever reaches that bit
  assign dbl_s = {req[NUM_REQ-2:0], req};

  // Rotate so bit 0 is the requester at rr_ptr
  always_comb begin
    rot_s = '0;
    idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s    = PW'(rr_ptr) + PW'(i);
      rot_s[i] = dbl_s[idx_s];
    end
  end

  // Lowest set bit of the rotated vector, mapped back to an absolute index
  always_comb begin
    found_s = 1'b0;
    off_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && rot_s[i]) begin
        found_s = 1'b1;
        off_s   = IDW'(i);
      end else begin
        found_s = found_s;
      end
    end
    sum_s = (IDW+1)'(rr_ptr) + (IDW+1)'(off_s);
    if (sum_s >= (IDW+1)'(NUM_REQ)) begin
      winner = IDW'(sum_s - (IDW+1)'(NUM_REQ));
    end else begin
      winner = IDW'(sum_s);
    end
  end

  assign any = |req;

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin owner arbiter for the shared bridge interface with turnaround
// and bounded hold. Optional `lock` input when BRIDGE_ARB_LOCK_EN is defined.
module bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int HW  = $clog2(MAX_HOLD+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
`ifdef BRIDGE_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               timeout
);

  arb_state_t         state_r, state_nxt_s;
  logic [HW-1:0]      hold_cnt_r, hold_nxt_s;
  logic [IDW-1:0]     rr_ptr_r, ptr_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  logic [IDW-1:0]     grant_id_r, id_nxt_s;
  logic               busy_r, timeout_r, timeout_nxt_s;
  logic [IDW-1:0]     winner_s;
  logic               any_s;
  logic               lock_s;
  logic               release_s;
  logic [IDW-1:0]     ptr_after_s;

`ifdef BRIDGE_ARB_LOCK_EN
  assign lock_s = lock;
`else
  assign lock_s = 1'b0;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  // Pointer moves just past the releasing owner, wrapping to zero
  always_comb begin
    if (grant_id_r == IDW'(NUM_REQ-1)) begin
      ptr_after_s = '0;
    end else begin
      ptr_after_s = grant_id_r + IDW'(1);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s   = state_r;
    hold_nxt_s    = hold_cnt_r;
    ptr_nxt_s     = rr_ptr_r;
    grant_nxt_s   = grant_r;
    id_nxt_s      = grant_id_r;
    timeout_nxt_s = 1'b0;
    release_s     = 1'b0;
    case (state_r)
      IDLE, TURN: begin
        if (any_s) begin
          grant_nxt_s = NUM_REQ'(1) << winner_s;
          id_nxt_s    = winner_s;
          hold_nxt_s  = '0;
          state_nxt_s = GRANT;
        end else begin
          grant_nxt_s = '0;
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        // done beats withdrawal beats timeout; a simultaneous done hides the timeout
        if (done[grant_id_r] || !req[grant_id_r]) begin
          release_s = 1'b1;
        end else if (!lock_s && (hold_cnt_r == HW'(MAX_HOLD-1))) begin
          release_s     = 1'b1;
          timeout_nxt_s = 1'b1;
        end else if (!lock_s && (hold_cnt_r != {HW{1'b1}})) begin
          hold_nxt_s = hold_cnt_r + HW'(1);
        end else begin
          hold_nxt_s = hold_cnt_r;
        end
        if (release_s) begin
          grant_nxt_s = '0;
          ptr_nxt_s   = ptr_after_s;
          state_nxt_s = TURN;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        grant_nxt_s = '0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      hold_cnt_r <= '0;
      rr_ptr_r   <= '0;
      grant_r    <= '0;
      grant_id_r <= '0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      rr_ptr_r   <= ptr_nxt_s;
      grant_r    <= grant_nxt_s;
      grant_id_r <= id_nxt_s;
      busy_r     <= |grant_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  assign grant    = grant_r;
  assign grant_id = grant_id_r;
  assign busy     = busy_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: directed scenarios plus random
// traffic compared against an owner/pointer reference model.
module tb_bridge_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, done;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy, timeout;
`ifdef BRIDGE_ARB_LOCK_EN
  logic         lock;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: owner index (-1 = none), pointer, cycles owned so far
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_tmo   = 1'b0;

  always #5 clk = ~clk;

  bridge_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
`ifdef BRIDGE_ARB_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn, input logic lk);
    m_tmo = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner >= 0) begin
      if (dn[m_owner] || !rq[m_owner] || (!lk && m_held >= MH)) begin
        m_tmo   = !dn[m_owner] && rq[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (!lk) begin
        m_held++;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (rq[c]) begin
          m_owner = c;
          m_held  = 1;
          break;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn, input logic lk);
    logic [N-1:0] exp_grant;
    logic         lk_eff;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = dn;
`ifdef BRIDGE_ARB_LOCK_EN
    lock   = lk;
    lk_eff = lk;
`else
    lk_eff = 1'b0;
    if (lk) lk_eff = 1'b0;
`endif
    @(posedge clk);
    model_step(r, rq, dn, lk_eff);
    #1;
    exp_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
    check_value("grant", 32'(grant), 32'(exp_grant));
    check_value("busy", 32'(busy), 32'(m_owner >= 0));
    check_value("timeout", 32'(timeout), 32'(m_tmo));
    if (m_owner >= 0) check_value("grant_id", 32'(grant_id), 32'(m_owner));
  endtask

  initial begin
    int hi;
    bit seen;
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] rq, dn;
    bit prev_busy;

    rst = 1'b1; req = '0; done = '0;
`ifdef BRIDGE_ARB_LOCK_EN
    lock = 1'b0;
`endif
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // reset mid-grant, then confirm pointer restarted at 0
    step(1'b0, 4'b0010, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 4'b0000, 1'b0);
    check_value("ptr_after_rst", 32'(grant), 32'h1);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // single request and done
    step(1'b0, 4'b0100, 4'b0000, 1'b0);
    check_value("single_id", 32'(grant_id), 32'd2);
    step(1'b0, 4'b0100, 4'b0100, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // fairness: each owner signals done after 2 cycles of ownership
    prev_busy = 1'b0;
    for (int k = 0; k < 40 && order.size() < 5; k++) begin
      dn = (m_owner >= 0 && m_held == 2) ? N'(1) << m_owner : '0;
      step(1'b0, 4'b1111, dn, 1'b0);
      if (busy && !prev_busy) order.push_back(int'(grant_id));
      prev_busy = busy;
    end
    check_value("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) check_value("rr_order", 32'(order[i]), 32'(exp_order[i]));
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // timeout of a lone requester and its re-grant
    step(1'b0, 4'b0001, 4'b0000, 1'b0);
    hi = 0; seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (timeout) seen = 1'b1;
      else begin
        if (grant == 4'b0001) hi++;
        step(1'b0, 4'b0001, 4'b0000, 1'b0);
      end
    end
    check_value("timeout_seen", 32'(seen), 32'd1);
    check_value("hold_cycles", 32'(hi), 32'(MH));
    check_value("turn_gap", 32'(grant), 32'h0);
    step(1'b0, 4'b0001, 4'b0000, 1'b0);
    check_value("regrant", 32'(grant), 32'h1);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // stray done from a non-owner, then withdrawal
    step(1'b0, 4'b1010, 4'b0000, 1'b0);
    step(1'b0, 4'b1010, 4'b1000, 1'b0);
    check_value("stray_done", 32'(grant), 32'b0010);
    step(1'b0, 4'b1000, 4'b0000, 1'b0);
    check_value("withdraw", 32'(grant), 32'h0);
    step(1'b0, 4'b1000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

`ifdef BRIDGE_ARB_LOCK_EN
    // lock holds the grant past MAX_HOLD; the count resumes when it drops
    step(1'b0, 4'b0001, 4'b0000, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, 4'b0001, 4'b0000, 1'b1);
    check_value("lock_hold", 32'(grant), 32'h1);
    for (int k = 0; k < 12; k++) step(1'b0, 4'b0001, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
`endif

    // random traffic
    for (int k = 0; k < 800; k++) begin
      rq = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0 && m_owner >= 0) rq[m_owner] = 1'b1;
      dn = N'($urandom) & N'($urandom) & N'($urandom);
      step($urandom_range(0, 99) == 0, rq, dn, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
